// File: rtl/uart_receiver_if.sv
// Byte output channel of the UART receiver: a valid/ready handshake
// plus the two one-cycle error strobes.
//
// Handshake: the receiver raises data_out_valid with a byte on data_out and
// holds both stable until a cycle in which data_out_ready is also high; that
// cycle is the transfer. Ready while valid is low means nothing.
interface uart_receiver_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun,
        output data_out_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. The line is synchronized, the start bit is confirmed at
// its midpoint, and every later bit is sampled one bit period after the
// previous sample. Completed bytes go out on a valid/ready channel; reception
// never waits for the consumer, so an unaccepted byte causes the next one to
// be dropped with an overrun strobe.
module uart_receiver #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serial_in,
    uart_receiver_if.master        rx_if,
    output logic [1:0]             fsm_state
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] EDGE_LAST   = CNT_W'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Decoded controls from the output process
    logic at_sample;
    logic at_edge;
    logic cnt_clr;
    logic shift_en;
    logic byte_done;
    logic frame_bad;
    logic load_byte;
    logic drop_byte;
    logic accept;

    assign fsm_state = state;

    // Two-flop synchronizer; flops rest at the idle line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx      <= rx_meta;
        end
    end

    // State register plus the bit counter and byte datapath it controls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            bit_idx              <= '0;
            shift_reg            <= '0;
            rx_if.data_out       <= 8'h00;
            rx_if.data_out_valid <= 1'b0;
            rx_if.framing_error  <= 1'b0;
            rx_if.overrun        <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_clr ? '0 : cnt + 1'b1;

            if (state == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (shift_en) begin
                shift_reg[bit_idx] <= rx;
            end

            if (load_byte) begin
                rx_if.data_out       <= shift_reg;
                rx_if.data_out_valid <= 1'b1;
            end else if (accept) begin
                rx_if.data_out_valid <= 1'b0;
            end

            rx_if.framing_error <= frame_bad;
            rx_if.overrun       <= drop_byte;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx) state_next = START;
            START: if (cnt == SAMPLE_LAST) state_next = rx ? IDLE : DATA;
            DATA:  if (cnt == EDGE_LAST && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (cnt == EDGE_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: counter restart, bit sampling and byte hand-off
    always_comb begin
        at_sample = (cnt == SAMPLE_LAST);
        at_edge   = (cnt == EDGE_LAST);
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        load_byte = 1'b0;
        drop_byte = 1'b0;
        accept    = rx_if.data_out_valid && rx_if.data_out_ready;

        case (state)
            IDLE:  cnt_clr = 1'b1;
            START: cnt_clr = at_sample;
            DATA: begin
                cnt_clr  = at_edge;
                shift_en = at_edge;
            end
            STOP: begin
                cnt_clr   = at_edge;
                byte_done = at_edge && rx;
                frame_bad = at_edge && !rx;
            end
            default: cnt_clr = 1'b1;
        endcase

        // A waiting byte can be replaced only in the cycle it is taken
        load_byte = byte_done && (!rx_if.data_out_valid || rx_if.data_out_ready);
        drop_byte = byte_done && rx_if.data_out_valid && !rx_if.data_out_ready;
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default parameters (434 clocks per bit).
module tb_uart_receiver;

    localparam int BIT_CYC = 434;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [1:0] fsm_state;

    uart_receiver_if rx_if ();

    uart_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_if     (rx_if.master),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;  // 50 MHz

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         valid_cycles = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe the output channel away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            if (prev_hold && rx_if.data_out_valid)
                check("data_stable", rx_if.data_out, prev_data);
            if (rx_if.data_out_valid && rx_if.data_out_ready)
                got_q.push_back(rx_if.data_out);
            if (rx_if.data_out_valid) valid_cycles++;
            if (rx_if.framing_error) fe_cnt++;
            if (rx_if.overrun) ov_cnt++;
            prev_hold = rx_if.data_out_valid && !rx_if.data_out_ready;
            prev_data = rx_if.data_out;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame. A bad stop bit is held low only long enough to be
    // sampled, so the line is clearly idle again before the next edge search.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        serial_in = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(BIT_CYC);
        end
        serial_in = stop_ok;
        tick(stop_ok ? BIT_CYC : 300);
        serial_in = 1'b1;
    endtask

    task automatic clear_counts();
        valid_cycles = 0;
        fe_cnt       = 0;
        ov_cnt       = 0;
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  rx_if.data_out, 8'h00);
        check({tag, "_valid"}, rx_if.data_out_valid, 1'b0);
        check({tag, "_fe"},    rx_if.framing_error, 1'b0);
        check({tag, "_ov"},    rx_if.overrun, 1'b0);
        check({tag, "_state"}, fsm_state, 2'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst                  = 1'b0;
        serial_in            = 1'b1;
        rx_if.data_out_ready = 1'b1;
        tick(5);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(20);

        // Single byte, consumer always ready
        clear_counts();
        exp_q.push_back(8'h61);
        send_byte(8'h61, 1'b1);
        tick(2 * BIT_CYC);
        check("t61_valid_cycles", valid_cycles, 1);
        check("t61_fe", fe_cnt, 0);
        check("t61_ov", ov_cnt, 0);
        compare_queues("t61");

        // Back-to-back frames, no idle gap
        clear_counts();
        exp_q.push_back(8'h73);
        exp_q.push_back(8'h77);
        send_byte(8'h73, 1'b1);
        send_byte(8'h77, 1'b1);
        tick(2 * BIT_CYC);
        check("b2b_ov", ov_cnt, 0);
        compare_queues("b2b");

        // Bad stop bit, then a good frame
        clear_counts();
        send_byte(8'h55, 1'b0);
        tick(2 * BIT_CYC);
        check("frm_fe", fe_cnt, 1);
        check("frm_valid_cycles", valid_cycles, 0);
        check("frm_data_kept", rx_if.data_out, 8'h77);
        compare_queues("frm");
        clear_counts();
        exp_q.push_back(8'h0d);
        send_byte(8'h0d, 1'b1);
        tick(2 * BIT_CYC);
        check("after_frm_fe", fe_cnt, 0);
        compare_queues("after_frm");

        // Short low glitch on an idle line
        clear_counts();
        serial_in = 1'b0;
        tick(BIT_CYC / 4);
        serial_in = 1'b1;
        tick(2 * BIT_CYC);
        check("glitch_valid_cycles", valid_cycles, 0);
        check("glitch_fe", fe_cnt, 0);
        check("glitch_state", fsm_state, 2'd0);
        compare_queues("glitch");
        clear_counts();
        exp_q.push_back(8'h20);
        send_byte(8'h20, 1'b1);
        tick(2 * BIT_CYC);
        compare_queues("after_glitch");

        // Consumer stalled: second byte is dropped
        clear_counts();
        rx_if.data_out_ready = 1'b0;
        send_byte(8'h31, 1'b1);
        send_byte(8'h35, 1'b1);
        tick(BIT_CYC);
        check("ovr_data", rx_if.data_out, 8'h31);
        check("ovr_valid", rx_if.data_out_valid, 1'b1);
        check("ovr_pulses", ov_cnt, 1);
        check("ovr_fe", fe_cnt, 0);
        compare_queues("ovr_held");
        exp_q.push_back(8'h31);
        rx_if.data_out_ready = 1'b1;
        tick(2);
        check("ovr_valid_drop", rx_if.data_out_valid, 1'b0);
        compare_queues("ovr_accept");

        // Reset during bit 3 of 8'hca, then a clean frame
        clear_counts();
        serial_in = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 3; i++) begin
            serial_in = (8'hca >> i) & 8'h01;
            tick(BIT_CYC);
        end
        serial_in = 1'b1;  // bit 3 of 8'hca
        tick(200);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick(5);
        check_reset_outputs("midrst_hold");
        rst = 1'b1;
        tick(2 * BIT_CYC);
        check("midrst_valid_cycles", valid_cycles, 0);
        exp_q.push_back(8'hfe);
        send_byte(8'hfe, 1'b1);
        tick(2 * BIT_CYC);
        check("midrst_fe", fe_cnt, 0);
        compare_queues("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
